// File: rtl/qspi_model_pkg.sv
// Shared opcodes, FSM states and output-enable patterns for the QSPI memory responder.
package qspi_model_pkg;

    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_FREAD  = 8'h0B;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_QREAD  = 8'hEB;
    localparam logic [7:0] OP_QWRITE = 8'h38;

    localparam logic [3:0] OE_OFF    = 4'b0000;
    localparam logic [3:0] OE_SERIAL = 4'b0010;
    localparam logic [3:0] OE_QUAD   = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    function automatic logic op_is_known(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_FREAD) || (op == OP_WRITE) ||
               (op == OP_QREAD) || (op == OP_QWRITE);
    endfunction

    function automatic logic op_is_write(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_QWRITE);
    endfunction

    function automatic logic op_is_quad(input logic [7:0] op);
        return (op == OP_QREAD) || (op == OP_QWRITE);
    endfunction

    function automatic logic op_has_dummy(input logic [7:0] op);
        return (op == OP_FREAD) || (op == OP_QREAD);
    endfunction

endpackage

// File: rtl/qspi_edge_sync.sv
// Two-flop synchroniser for the QSPI bus plus SCLK edge and chip-select transition pulses.
module qspi_edge_sync #(
    parameter int NUM_CS = 2
) (
    input  logic              clk,
    input  logic              i_sclk,
    input  logic [NUM_CS-1:0] i_cs_n,
    input  logic [3:0]        i_io,
    output logic              o_sclk_rise,
    output logic              o_sclk_fall,
    output logic              o_cs_fall,
    output logic              o_cs_rise,
    output logic [NUM_CS-1:0] o_cs_n,
    output logic [3:0]        o_io
);

    logic              r_sclk_m, r_sclk_s, r_sclk_q;
    logic [NUM_CS-1:0] r_cs_m, r_cs_s, r_cs_q;
    logic [3:0]        r_io_m, r_io_s;

    // Left unreset so a reset mid-transaction cannot fake an all-deselected bus.
    always_ff @(posedge clk) begin
        r_sclk_m <= i_sclk;
        r_sclk_s <= r_sclk_m;
        r_sclk_q <= r_sclk_s;
        r_cs_m   <= i_cs_n;
        r_cs_s   <= r_cs_m;
        r_cs_q   <= r_cs_s;
        r_io_m   <= i_io;
        r_io_s   <= r_io_m;
    end

    assign o_sclk_rise = r_sclk_s & ~r_sclk_q;
    assign o_sclk_fall = ~r_sclk_s & r_sclk_q;
    assign o_cs_fall   = (&r_cs_q) & ~(&r_cs_s);
    assign o_cs_rise   = (&r_cs_s) & ~(&r_cs_q);
    assign o_cs_n      = r_cs_s;
    assign o_io        = r_io_s;

endmodule

// File: rtl/qspi_mem_model.sv
// Multi-device QSPI memory responder: decodes serial/quad read and write commands sampled on clk,
// drives read data on SCLK falls, and exposes a backdoor byte port into each device's memory.
module qspi_mem_model
    import qspi_model_pkg::*;
#(
    parameter int                NUM_CS       = 2,
    parameter int                DEPTH_BYTES  = 65536,
    parameter int                ADDR_BITS    = 24,
    parameter int                DUMMY_CYCLES = 6,
    parameter logic [NUM_CS-1:0] WRITABLE     = 2'b10,
    localparam int               AW           = $clog2(DEPTH_BYTES),
    localparam int               CSW          = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CS-1:0] cs_n,
    input  logic              sclk,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    input  logic              bd_we,
    input  logic [CSW-1:0]    bd_cs,
    input  logic [AW-1:0]     bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata,
    output logic              cmd_err,
    output logic              wp_err,
    output logic              cs_err,
    output logic              busy
);

    localparam int CNT_W = 6;
    localparam int MW    = CSW + AW;

    logic [7:0] r_mem [NUM_CS*DEPTH_BYTES];

    logic              w_rise, w_fall, w_cs_fall, w_cs_rise;
    logic [NUM_CS-1:0] w_cs_n;
    logic [3:0]        w_io;

    qspi_edge_sync #(.NUM_CS(NUM_CS)) u_sync (
        .clk         (clk),
        .i_sclk      (sclk),
        .i_cs_n      (cs_n),
        .i_io        (io_in),
        .o_sclk_rise (w_rise),
        .o_sclk_fall (w_fall),
        .o_cs_fall   (w_cs_fall),
        .o_cs_rise   (w_cs_rise),
        .o_cs_n      (w_cs_n),
        .o_io        (w_io)
    );

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_shift;
    logic [7:0]       r_op;
    logic             r_quad;
    logic [CSW-1:0]   r_cs_idx;
    logic [AW-1:0]    r_addr;
    logic [7:0]       r_rd_byte;
    logic [7:0]       r_wr_byte;
    logic             r_fetch;
    logic             r_multi_q;
    logic [3:0]       r_io_out, r_io_oe;
    logic             r_cmd_err, r_wp_err, r_cs_err, r_busy;

    logic [CSW:0]     w_low_cnt;
    logic [CSW-1:0]   w_sel_idx;
    logic             w_multi;
    logic [7:0]       w_op;
    logic [AW-1:0]    w_addr_nxt;
    logic [7:0]       w_wr_nxt;
    logic [CNT_W-1:0] w_addr_last, w_byte_last;
    logic [MW-1:0]    w_bus_idx;
    logic             w_bus_we;

    always_comb begin
        w_low_cnt = '0;
        w_sel_idx = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (!w_cs_n[i]) begin
                w_low_cnt = w_low_cnt + 1'b1;
                w_sel_idx = CSW'(i);
            end
        end
    end

    assign w_multi     = (w_low_cnt > (CSW+1)'(1));
    assign w_op        = {r_shift, w_io[0]};
    assign w_addr_nxt  = r_quad ? {r_addr[AW-5:0], w_io} : {r_addr[AW-2:0], w_io[0]};
    assign w_wr_nxt    = r_quad ? {r_wr_byte[3:0], w_io} : {r_wr_byte[6:0], w_io[0]};
    assign w_addr_last = r_quad ? CNT_W'(ADDR_BITS/4 - 1) : CNT_W'(ADDR_BITS - 1);
    assign w_byte_last = r_quad ? CNT_W'(1) : CNT_W'(7);
    assign w_bus_idx   = {r_cs_idx, r_addr};
    // A write commits only on the rise that completes a byte while the device is still selected.
    assign w_bus_we    = (r_state == ST_WDATA) && w_rise && !w_cs_rise && !w_multi &&
                         (r_cnt == w_byte_last);

    // Backdoor is written last so it overrides a same-cycle bus write to the same byte.
    always_ff @(posedge clk) begin
        if (w_bus_we)
            r_mem[w_bus_idx] <= w_wr_nxt;
        if (bd_we)
            r_mem[{bd_cs, bd_addr}] <= bd_wdata;
    end

    assign bd_rdata = r_mem[{bd_cs, bd_addr}];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_fetch   <= 1'b0;
            r_multi_q <= 1'b0;
            r_io_out  <= '0;
            r_io_oe   <= OE_OFF;
            r_cmd_err <= 1'b0;
            r_wp_err  <= 1'b0;
            r_cs_err  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            r_wp_err  <= 1'b0;
            r_cs_err  <= 1'b0;
            r_multi_q <= w_multi;
            if (w_cs_rise) begin
                r_state  <= ST_IDLE;
                r_io_oe  <= OE_OFF;
                r_io_out <= '0;
                r_busy   <= 1'b0;
                r_fetch  <= 1'b0;
            end else if (w_multi) begin
                r_cs_err <= !r_multi_q;
                r_state  <= ST_IGNORE;
                r_io_oe  <= OE_OFF;
                r_busy   <= 1'b1;
                r_fetch  <= 1'b0;
            end else begin
                unique case (r_state)
                    // Entry needs a fresh select edge, so a reset mid-transaction waits out the CS cycle.
                    ST_IDLE: if (w_cs_fall) begin
                        r_state  <= ST_CMD;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_cs_idx <= w_sel_idx;
                    end
                    ST_CMD: if (w_rise) begin
                        r_shift <= w_op[6:0];
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(7)) begin
                            r_cnt  <= '0;
                            r_op   <= w_op;
                            r_quad <= op_is_quad(w_op);
                            if (!op_is_known(w_op)) begin
                                r_cmd_err <= 1'b1;
                                r_state   <= ST_IGNORE;
                            end else if (op_is_write(w_op) && !WRITABLE[r_cs_idx]) begin
                                r_wp_err <= 1'b1;
                                r_state  <= ST_IGNORE;
                            end else begin
                                r_state <= ST_ADDR;
                            end
                        end
                    end
                    ST_ADDR: if (w_rise) begin
                        r_addr <= w_addr_nxt;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == w_addr_last) begin
                            r_cnt <= '0;
                            if (op_is_write(r_op)) begin
                                r_state <= ST_WDATA;
                            end else if (op_has_dummy(r_op) && DUMMY_CYCLES > 0) begin
                                r_state <= ST_DUMMY;
                            end else begin
                                r_state <= ST_RDATA;
                                r_fetch <= 1'b1;
                            end
                        end
                    end
                    ST_DUMMY: if (w_rise) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ST_RDATA;
                            r_fetch <= 1'b1;
                        end
                    end
                    ST_RDATA: begin
                        if (r_fetch) begin
                            r_rd_byte <= r_mem[w_bus_idx];
                            r_fetch   <= 1'b0;
                        end else if (w_fall) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_quad) begin
                                r_io_oe   <= OE_QUAD;
                                r_io_out  <= r_rd_byte[7:4];
                                r_rd_byte <= {r_rd_byte[3:0], 4'h0};
                            end else begin
                                r_io_oe   <= OE_SERIAL;
                                r_io_out  <= {2'b00, r_rd_byte[7], 1'b0};
                                r_rd_byte <= {r_rd_byte[6:0], 1'b0};
                            end
                            if (r_cnt == w_byte_last) begin
                                r_cnt   <= '0;
                                r_addr  <= r_addr + 1'b1;
                                r_fetch <= 1'b1;
                            end
                        end
                    end
                    ST_WDATA: if (w_rise) begin
                        r_wr_byte <= w_wr_nxt;
                        r_cnt     <= r_cnt + 1'b1;
                        if (r_cnt == w_byte_last) begin
                            r_cnt  <= '0;
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                    ST_IGNORE: ;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign io_out  = r_io_out;
    assign io_oe   = r_io_oe;
    assign cmd_err = r_cmd_err;
    assign wp_err  = r_wp_err;
    assign cs_err  = r_cs_err;
    assign busy    = r_busy;

endmodule
